uart_rx_pkt_ctrl: RTL and testbench
===================================

Name: uart_rx_pkt_ctrl

Overview:
Packet-level controller that sits directly behind the UART receiver, at 115200 baud and 50 MHz.
It consumes the receiver's byte stream (data byte, complete pulse, error pulse) and sequences frame reception: start-of-frame detect, length, payload, checksum, and inter-byte timeout.
Validated payloads are stored in an internal buffer and handed to the downstream consumer with a valid/ready handshake and a registered read port.

Parameters:
SYS_CLK, 50000000, system clock frequency in Hz.
BAUD_RATE, 115200, UART baud rate.
ADDR_W, 4, payload buffer address width; MAX_LEN = 2**ADDR_W bytes.
SOF, 8'hAA, start-of-frame byte.
TIMEOUT_BYTES, 4, inter-byte timeout in 10-bit character times; TIMEOUT_CYC = (SYS_CLK/BAUD_RATE)*10*TIMEOUT_BYTES (17360 at defaults).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_rx_d  input  8  received byte from the UART receiver
i_rx_complete  input  1  1-cycle pulse; i_rx_d is valid in this cycle
i_rx_error  input  1  1-cycle pulse; framing or stop-bit error on the current byte
o_pkt_valid  output  1  a complete, checksum-good packet is held in the buffer
i_pkt_ready  input  1  consumer accepts the packet
o_pkt_len  output  ADDR_W+1  payload length of the held packet (1..MAX_LEN)
i_rd_addr  input  ADDR_W  buffer read address
o_rd_data  output  8  buffer data; registered, 1-cycle latency
o_busy  output  1  high in any state other than IDLE
o_err_frame  output  1  1-cycle pulse: bad length, or i_rx_error during a frame
o_err_chk  output  1  1-cycle pulse: checksum mismatch
o_err_timeout  output  1  1-cycle pulse: inter-byte timeout expired
o_overrun  output  1  1-cycle pulse: byte dropped while in HOLD

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE.
  - All outputs = 0, including o_pkt_len and o_rd_data.
  - Byte counter, checksum accumulator and timeout counter = 0.
  - Buffer contents are don't-care.
  - Reset asserted mid-frame or in HOLD abandons the packet; no error pulse is generated.
- Frame format: SOF, LEN, LEN payload bytes, CHK.
  - CHK = XOR of LEN and all payload bytes.
- States and transitions, evaluated on cycles with i_rx_complete=1:
  - IDLE:
    - Byte == SOF -> LEN state; clear checksum and timeout counter.
    - Any other byte is discarded silently.
    - i_rx_error is ignored.
  - LEN:
    - Byte in 1..MAX_LEN -> latch length, checksum = byte, write address = 0 -> PAYLOAD.
    - Byte 0 or > MAX_LEN -> o_err_frame pulse -> IDLE.
  - PAYLOAD:
    - Write the byte to buffer[addr], XOR it into the checksum, addr++.
    - After the LEN-th byte -> CHK.
  - CHK:
    - Byte == checksum -> HOLD; o_pkt_valid=1 and o_pkt_len=LEN in the same cycle as the state entry.
    - Mismatch -> o_err_chk pulse -> IDLE.
  - HOLD:
    - o_pkt_valid stays high until the cycle in which o_pkt_valid && i_pkt_ready.
    - In the next cycle: o_pkt_valid=0 -> IDLE.
    - Any i_rx_complete while in HOLD (including the handshake cycle) drops the byte and pulses o_overrun.
    - i_rx_error in HOLD is ignored.
- Error precedence:
  - i_rx_error in LEN/PAYLOAD/CHK -> o_err_frame pulse -> IDLE.
  - If i_rx_complete and i_rx_error are high in the same cycle, the error wins and the byte is not consumed.
- Timeout:
  - The counter runs in LEN/PAYLOAD/CHK and clears on every i_rx_complete.
  - On reaching TIMEOUT_CYC-1: o_err_timeout pulse -> IDLE.
  - The counter is held at 0 in IDLE and HOLD.
  - If timeout expiry and i_rx_complete coincide, the byte wins and the counter clears.
- Error pulses are exactly 1 cycle and mutually exclusive per cycle. Pulses appear the cycle after the causing event (registered).
- Read port:
  - o_rd_data <= buffer[i_rd_addr] on every clock.
  - Contents are guaranteed only while o_pkt_valid=1.
  - Addresses >= o_pkt_len return stale data.
- The buffer is never written outside PAYLOAD. A new packet cannot overwrite a held packet.
- o_pkt_len holds its value after the handshake until the next HOLD entry.

Test Plan:
1. Good frame: bytes AA 03 11 22 33 03 with ready=0 -> o_pkt_valid=1, o_pkt_len=3; reads at addr 0/1/2 return 11/22/33 one cycle later; raise ready -> valid drops the next cycle and o_busy=0.
2. Checksum error: AA 02 55 66 00 (correct CHK=0x31) -> one o_err_chk pulse, o_pkt_valid stays 0, state IDLE; a following good frame is accepted.
3. Length bounds: AA 00 -> o_err_frame; AA 11 (17 > MAX_LEN 16) -> o_err_frame; AA 10, 16 payload bytes, correct CHK -> valid with o_pkt_len=16.
4. Timeout: AA 02 11, then idle 17360 cycles -> o_err_timeout pulse, IDLE; a gap of 17359 cycles followed by a byte -> no timeout.
5. Errors mid-frame: i_rx_error during PAYLOAD -> o_err_frame, IDLE; i_rx_complete together with i_rx_error in LEN -> o_err_frame, byte ignored.
6. HOLD overrun and reset: send a byte while valid=1 -> o_overrun pulse and the held data is unchanged; assert rst_n=0 mid-PAYLOAD -> all outputs 0 immediately, with no error pulse.

Source files
------------

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet sequencer behind a UART receiver: SOF / LEN / payload / XOR checksum framing
// with inter-byte timeout, a payload buffer and a valid/ready hand-off to the consumer.
module uart_rx_pkt_ctrl #(
  parameter int         SYS_CLK       = 50000000,
  parameter int         BAUD_RATE     = 115200,
  parameter int         ADDR_W        = 4,
  parameter logic [7:0] SOF           = 8'hAA,
  parameter int         TIMEOUT_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_rx_d,
  input  logic              i_rx_complete,
  input  logic              i_rx_error,
  output logic              o_pkt_valid,
  input  logic              i_pkt_ready,
  output logic [ADDR_W:0]   o_pkt_len,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data,
  output logic              o_busy,
  output logic              o_err_frame,
  output logic              o_err_chk,
  output logic              o_err_timeout,
  output logic              o_overrun
);

  localparam int          MAX_LEN     = 2 ** ADDR_W;
  localparam logic [31:0] MAX_LEN_U   = MAX_LEN;
  localparam int          TIMEOUT_CYC = (SYS_CLK / BAUD_RATE) * 10 * TIMEOUT_BYTES;
  localparam int          TO_W        = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ADDR_W:0] r_len;
  logic [ADDR_W:0] r_cnt;
  logic [7:0]      r_chk;
  logic [TO_W-1:0] r_to_cnt;
  logic [ADDR_W:0] r_pkt_len;
  logic [7:0]      r_rd_data;
  logic [7:0]      r_mem [MAX_LEN];
  logic            r_err_frame;
  logic            r_err_chk;
  logic            r_err_timeout;
  logic            r_overrun;

  logic w_active;
  logic w_len_ok;
  logic w_wr_en;
  logic w_err_frame_nxt;
  logic w_err_chk_nxt;
  logic w_err_to_nxt;
  logic w_overrun_nxt;

  assign w_active = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
  assign w_len_ok = (i_rx_d != 8'd0) && ({24'd0, i_rx_d} <= MAX_LEN_U);

  // Handshake: o_pkt_valid is high for the whole HOLD state and the packet is
  // transferred in the cycle where o_pkt_valid && i_pkt_ready; valid drops next cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_en         = 1'b0;
    w_err_frame_nxt = 1'b0;
    w_err_chk_nxt   = 1'b0;
    w_err_to_nxt    = 1'b0;
    w_overrun_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_rx_complete && !i_rx_error && (i_rx_d == SOF)) w_state_nxt = S_LEN;
      end
      S_LEN, S_PAYLOAD, S_CHK: begin
        if (i_rx_error) begin
          w_err_frame_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end else if (i_rx_complete) begin
          if (r_state == S_LEN) begin
            if (w_len_ok) begin
              w_state_nxt = S_PAYLOAD;
            end else begin
              w_err_frame_nxt = 1'b1;
              w_state_nxt     = S_IDLE;
            end
          end else if (r_state == S_PAYLOAD) begin
            w_wr_en = 1'b1;
            if (r_cnt == (r_len - 1'b1)) w_state_nxt = S_CHK;
          end else begin
            if (i_rx_d == r_chk) begin
              w_state_nxt = S_HOLD;
            end else begin
              w_err_chk_nxt = 1'b1;
              w_state_nxt   = S_IDLE;
            end
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_err_to_nxt = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      S_HOLD: begin
        w_overrun_nxt = i_rx_complete;
        if (i_pkt_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_cnt         <= '0;
      r_chk         <= '0;
      r_to_cnt      <= '0;
      r_pkt_len     <= '0;
      r_err_frame   <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_err_frame   <= w_err_frame_nxt;
      r_err_chk     <= w_err_chk_nxt;
      r_err_timeout <= w_err_to_nxt;
      r_overrun     <= w_overrun_nxt;
      // Counts idle cycles only while a frame is open and the state is unchanged.
      if (w_active && !i_rx_complete && (w_state_nxt == r_state)) r_to_cnt <= r_to_cnt + 1'b1;
      else                                                          r_to_cnt <= '0;
      if ((r_state == S_IDLE) && (w_state_nxt == S_LEN)) begin
        r_chk <= '0;
        r_cnt <= '0;
      end
      if ((r_state == S_LEN) && (w_state_nxt == S_PAYLOAD)) begin
        r_len <= (ADDR_W+1)'(i_rx_d);
        r_chk <= i_rx_d;
        r_cnt <= '0;
      end
      if (w_wr_en) begin
        r_chk <= r_chk ^ i_rx_d;
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == S_CHK) && (w_state_nxt == S_HOLD)) r_pkt_len <= r_len;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_cnt[ADDR_W-1:0]] <= i_rx_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_pkt_valid   = (r_state == S_HOLD);
  assign o_busy        = (r_state != S_IDLE);
  assign o_pkt_len     = r_pkt_len;
  assign o_rd_data     = r_rd_data;
  assign o_err_frame   = r_err_frame;
  assign o_err_chk     = r_err_chk;
  assign o_err_timeout = r_err_timeout;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scenario bench for uart_rx_pkt_ctrl: payload bytes go to an expected queue as frames
// are sent and are popped against the buffer read port once the packet is held.
module tb_uart_rx_pkt_ctrl;
  localparam int ADDR_W = 4;
  localparam int TO_CYC = 17360;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        i_rx_d = 8'h00;
  logic              i_rx_complete = 1'b0;
  logic              i_rx_error = 1'b0;
  logic              o_pkt_valid;
  logic              i_pkt_ready = 1'b0;
  logic [ADDR_W:0]   o_pkt_len;
  logic [ADDR_W-1:0] i_rd_addr = '0;
  logic [7:0]        o_rd_data;
  logic              o_busy;
  logic              o_err_frame;
  logic              o_err_chk;
  logic              o_err_timeout;
  logic              o_overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int n_frame = 0;
  int n_chk   = 0;
  int n_to    = 0;
  int n_ovr   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pay [16];

  uart_rx_pkt_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rx_d        (i_rx_d),
    .i_rx_complete (i_rx_complete),
    .i_rx_error    (i_rx_error),
    .o_pkt_valid   (o_pkt_valid),
    .i_pkt_ready   (i_pkt_ready),
    .o_pkt_len     (o_pkt_len),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_busy        (o_busy),
    .o_err_frame   (o_err_frame),
    .o_err_chk     (o_err_chk),
    .o_err_timeout (o_err_timeout),
    .o_overrun     (o_overrun)
  );

  // clock / reset
  always #10 clk = ~clk;

  // pulse counters, sampled on the inactive edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_err_frame)   n_frame++;
      if (o_err_chk)     n_chk++;
      if (o_err_timeout) n_to++;
      if (o_overrun)     n_ovr++;
    end
  end

  // driver tasks: called at a negedge, return at the following negedge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic cmp, input logic err);
    i_rx_d        = b;
    i_rx_complete = cmp;
    i_rx_error    = err;
    @(negedge clk);
    i_rx_complete = 1'b0;
    i_rx_error    = 1'b0;
  endtask

  task automatic send_frame(input int len);
    logic [7:0] chk;
    chk = 8'(len);
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'(len), 1'b1, 1'b0);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(pay[i]);
      chk = chk ^ pay[i];
      send_byte(pay[i], 1'b1, 1'b0);
    end
    send_byte(chk, 1'b1, 1'b0);
  endtask

  // scoreboard: pop expected payload and compare against the registered read port
  task automatic sb_drain(input int len);
    logic [7:0] e;
    n_tests++;
    if (o_pkt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_valid: got %b expected 1", o_pkt_valid);
    end
    n_tests++;
    if (o_pkt_len !== 5'(len)) begin
      n_fail++;
      $display("FAIL sb_len: got %0d expected %0d", o_pkt_len, len);
    end
    for (int i = 0; i < len; i++) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: queue empty at index %0d expected %0d entries", i, len);
        break;
      end
      e = exp_q.pop_front();
      i_rd_addr = 4'(i);
      @(negedge clk);
      n_tests++;
      if (o_rd_data !== e) begin
        n_fail++;
        $display("FAIL sb_data[%0d]: got %h expected %h", i, o_rd_data, e);
      end
    end
    exp_q.delete();
  endtask

  task automatic handshake();
    n_tests++;
    if (o_pkt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_pre_valid: got %b expected 1", o_pkt_valid);
    end
    i_pkt_ready = 1'b1;
    @(negedge clk);
    i_pkt_ready = 1'b0;
    n_tests++;
    if ({o_pkt_valid, o_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL hs_post: got valid/busy %b expected 00", {o_pkt_valid, o_busy});
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({o_pkt_valid, o_busy, o_pkt_len, o_rd_data, o_err_frame, o_err_chk, o_err_timeout, o_overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b busy=%b len=%0d data=%h errs=%b%b%b%b expected all 0",
               o_pkt_valid, o_busy, o_pkt_len, o_rd_data, o_err_frame, o_err_chk, o_err_timeout, o_overrun);
    end
    idle(3);
    rst_n = 1'b1;
    idle(2);
    n_tests++;
    if ({o_pkt_valid, o_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: got valid/busy %b expected 00", {o_pkt_valid, o_busy});
    end
  endtask

  task automatic test_good_frame();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_frame(3);
    n_tests++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL good_busy: got %b expected 1", o_busy);
    end
    sb_drain(3);
    handshake();
    n_tests++;
    if (o_pkt_len !== 5'd3) begin
      n_fail++;
      $display("FAIL good_len_after_hs: got %0d expected 3", o_pkt_len);
    end
  endtask

  task automatic test_chk_error();
    int c0;
    c0 = n_chk;
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h55, 1'b1, 1'b0);
    send_byte(8'h66, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    idle(3);
    n_tests++;
    if ((n_chk - c0) !== 1) begin
      n_fail++;
      $display("FAIL chk_pulse: got %0d pulses expected 1", n_chk - c0);
    end
    n_tests++;
    if ({o_pkt_valid, o_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL chk_state: got valid/busy %b expected 00", {o_pkt_valid, o_busy});
    end
    pay[0] = 8'h55; pay[1] = 8'h66;
    send_frame(2);
    sb_drain(2);
    handshake();
  endtask

  task automatic test_len_bounds();
    int f0;
    f0 = n_frame;
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    idle(3);
    n_tests++;
    if ((n_frame - f0) !== 1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len_zero: got %0d pulses busy=%b expected 1 pulse busy=0", n_frame - f0, o_busy);
    end
    f0 = n_frame;
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0);
    idle(3);
    n_tests++;
    if ((n_frame - f0) !== 1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len_17: got %0d pulses busy=%b expected 1 pulse busy=0", n_frame - f0, o_busy);
    end
    for (int i = 0; i < 16; i++) pay[i] = 8'($urandom_range(0, 255));
    send_frame(16);
    sb_drain(16);
    handshake();
  endtask

  task automatic test_timeout();
    int t0;
    t0 = n_to;
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0);
    idle(TO_CYC - 1);
    n_tests++;
    if ((n_to - t0) !== 0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL to_early: got %0d pulses busy=%b expected 0 pulses busy=1", n_to - t0, o_busy);
    end
    idle(3);
    n_tests++;
    if ((n_to - t0) !== 1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_fire: got %0d pulses busy=%b expected 1 pulse busy=0", n_to - t0, o_busy);
    end
    t0 = n_to;
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0);
    idle(TO_CYC - 1);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h31, 1'b1, 1'b0);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    sb_drain(2);
    n_tests++;
    if ((n_to - t0) !== 0) begin
      n_fail++;
      $display("FAIL to_gap: got %0d pulses expected 0", n_to - t0);
    end
    handshake();
  endtask

  task automatic test_mid_errors();
    int f0;
    f0 = n_frame;
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b0, 1'b1);
    idle(3);
    n_tests++;
    if ((n_frame - f0) !== 1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_payload: got %0d pulses busy=%b expected 1 pulse busy=0", n_frame - f0, o_busy);
    end
    f0 = n_frame;
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b1);
    idle(3);
    n_tests++;
    if ((n_frame - f0) !== 1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_len_both: got %0d pulses busy=%b expected 1 pulse busy=0", n_frame - f0, o_busy);
    end
  endtask

  task automatic test_overrun_reset();
    int o0, f0, c0, t0;
    pay[0] = 8'hA5; pay[1] = 8'h5A;
    send_frame(2);
    o0 = n_ovr;
    send_byte(8'h77, 1'b1, 1'b0);
    idle(3);
    n_tests++;
    if ((n_ovr - o0) !== 1) begin
      n_fail++;
      $display("FAIL overrun_pulse: got %0d pulses expected 1", n_ovr - o0);
    end
    sb_drain(2);
    handshake();
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h04, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    f0 = n_frame; c0 = n_chk; t0 = n_to; o0 = n_ovr;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_pkt_valid, o_busy, o_pkt_len, o_rd_data, o_err_frame, o_err_chk, o_err_timeout, o_overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got valid=%b busy=%b len=%0d data=%h errs=%b%b%b%b expected all 0",
               o_pkt_valid, o_busy, o_pkt_len, o_rd_data, o_err_frame, o_err_chk, o_err_timeout, o_overrun);
    end
    idle(2);
    rst_n = 1'b1;
    idle(4);
    n_tests++;
    if ((n_frame - f0) + (n_chk - c0) + (n_to - t0) + (n_ovr - o0) !== 0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_err: got %0d pulses busy=%b expected 0 pulses busy=0",
               (n_frame - f0) + (n_chk - c0) + (n_to - t0) + (n_ovr - o0), o_busy);
    end
    pay[0] = 8'h3C;
    send_frame(1);
    sb_drain(1);
    handshake();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_chk_error();
    test_len_bounds();
    test_timeout();
    test_mid_errors();
    test_overrun_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
